memory_access: RTL and testbench

Pipeline stage directly downstream of execute: accepts the registered ALU result, destination register and memory controls, performs the data-memory load or store over a request/grant/response bus, and presents the writeback triple (register select, write enable, data) to the writeback stage. It aligns store data with byte enables, extracts and sign- or zero-extends load data, flags misaligned accesses, and asserts `stall_o` to freeze upstream stages while a memory transaction is outstanding.

---
 rtl/memory_access_pkg.sv | 38 +++
 rtl/memory_access_load_align.sv | 24 ++
 rtl/memory_access.sv | 134 +++++++++++++
 tb/tb_memory_access.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared types and store-side helpers for the memory access stage.
// SIZE_B is encoded as zero so that a cleared bubble decodes as a byte access.
package memory_access_pkg;

  typedef enum logic [2:0] {
    SIZE_B  = 3'd0,
    SIZE_H  = 3'd1,
    SIZE_W  = 3'd2,
    SIZE_BU = 3'd3,
    SIZE_HU = 3'd4
  } data_size_e;

  function automatic logic is_misaligned(input data_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_H, SIZE_HU: return offset[0];
      SIZE_W:          return offset != 2'b00;
      default:         return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input data_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_H, SIZE_HU: return 4'b0011 << {offset[1], 1'b0};
      SIZE_W:          return 4'hF;
      default:         return 4'b0001 << offset;
    endcase
  endfunction

  // Data is replicated into every lane so the byte enables alone pick the target bytes.
  function automatic logic [31:0] store_data(input data_size_e size, input logic [31:0] rs2);
    case (size)
      SIZE_H, SIZE_HU: return {2{rs2[15:0]}};
      SIZE_W:          return rs2;
      default:         return {4{rs2[7:0]}};
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_align.sv
// Combinational load extraction: shifts the addressed lane down and sign/zero extends it.
module load_align
  import memory_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  data_size_e  size,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SIZE_B:  data = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_BU: data = {24'h0, shifted[7:0]};
      SIZE_H:  data = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_HU: data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory access pipeline stage: issues loads/stores on a req/gnt/rvalid bus and
// produces the writeback triple, stalling upstream while a transaction is open.
module memory_access
  import memory_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  sel_rd_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  input  data_size_e  mem_size_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] rs2_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [4:0]  sel_rd_o,
  output logic        rd_we_o,
  output logic [31:0] rd_data_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;

  mem_state_e  state, state_next;
  logic [31:0] addr_q, wdata_q, rd_data_q, load_data;
  data_size_e  size_q;
  logic        we_q, rd_we_q, misalign_q;
  logic [4:0]  rd_q, sel_rd_q;
  logic [3:0]  be_q;
  logic        mem_op, misaligned, issue;

  assign mem_op     = mem_re_i | mem_we_i;
  assign misaligned = is_misaligned(mem_size_i, alu_result_i[1:0]);
  assign issue      = (state == IDLE) && mem_op && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // stall and req decode from state alone, so upstream never sees a combinational input path.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    dmem_req_o = 1'b0;
    case (state)
      IDLE: if (mem_op && !misaligned) state_next = REQ;
      REQ: begin
        stall_o    = 1'b1;
        dmem_req_o = 1'b1;
        if (dmem_gnt_i) state_next = we_q ? IDLE : RESP;
      end
      RESP: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      size_q  <= SIZE_B;
      we_q    <= 1'b0;
      rd_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (issue) begin
      addr_q  <= alu_result_i;
      size_q  <= mem_size_i;
      we_q    <= mem_we_i;
      rd_q    <= sel_rd_i;
      be_q    <= byte_enable(mem_size_i, alu_result_i[1:0]);
      wdata_q <= store_data(mem_size_i, rs2_i);
    end
  end

  load_align u_load_align (
    .rdata  (dmem_rdata_i),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .data   (load_data)
  );

  // Any memory op, issued or dropped, leaves a bubble that holds until the load returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_rd_q   <= '0;
      rd_we_q    <= 1'b0;
      rd_data_q  <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      case (state)
        IDLE: begin
          misalign_q <= mem_op && misaligned;
          if (mem_op) begin
            sel_rd_q  <= '0;
            rd_we_q   <= 1'b0;
            rd_data_q <= '0;
          end else begin
            sel_rd_q  <= sel_rd_i;
            rd_we_q   <= sel_rd_i != 5'd0;
            rd_data_q <= alu_result_i;
          end
        end
        RESP: if (dmem_rvalid_i) begin
          sel_rd_q  <= rd_q;
          rd_we_q   <= rd_q != 5'd0;
          rd_data_q <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = {addr_q[31:2], 2'b00};
  assign dmem_be_o    = be_q;
  assign dmem_wdata_o = wdata_q;
  assign sel_rd_o     = sel_rd_q;
  assign rd_we_o      = rd_we_q;
  assign rd_data_o    = rd_data_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access with hand-computed expectations.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  sel_rd_i;
  logic        mem_re_i, mem_we_i;
  data_size_e  mem_size_i;
  logic [31:0] alu_result_i, rs2_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  sel_rd_o;
  logic        rd_we_o;
  logic [31:0] rd_data_o;
  logic        misalign_o;

  int errors = 0;
  int checks = 0;

  memory_access dut (
    .clk(clk), .rst_n(rst_n), .sel_rd_i(sel_rd_i), .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .alu_result_i(alu_result_i), .rs2_i(rs2_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .sel_rd_o(sel_rd_o),
    .rd_we_o(rd_we_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rd, input logic re, input logic we, input data_size_e size,
                        input logic [31:0] alu, input logic [31:0] rs2);
    sel_rd_i = rd; mem_re_i = re; mem_we_i = we; mem_size_i = size;
    alu_result_i = alu; rs2_i = rs2;
  endtask

  task automatic set_nop();
    set_op(5'd0, 1'b0, 1'b0, SIZE_B, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    #5;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, sel_rd_o, rd_we_o, rd_data_o, misalign_o} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: got nonzero outputs stall=%b req=%b rd_we=%b data=%h, expected all zero", stall_o, dmem_req_o, rd_we_o, rd_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    set_op(5'd5, 1'b0, 1'b0, SIZE_W, 32'h1234, 32'h0);
    tick();
    set_op(5'd0, 1'b0, 1'b0, SIZE_W, 32'hDEAD, 32'h0);
    checks++; if ({rd_we_o, sel_rd_o, rd_data_o, stall_o} !== {1'b1, 5'd5, 32'h1234, 1'b0}) begin
      errors++; $display("[TB] FAIL alu_wb: got we=%b rd=%0d data=%h stall=%b, expected we=1 rd=5 data=00001234 stall=0", rd_we_o, sel_rd_o, rd_data_o, stall_o); end
    tick();
    set_nop();
    checks++; if ({rd_we_o, sel_rd_o, rd_data_o} !== {1'b0, 5'd0, 32'hDEAD}) begin
      errors++; $display("[TB] FAIL alu_rd0: got we=%b rd=%0d data=%h, expected we=0 rd=0 data=0000dead", rd_we_o, sel_rd_o, rd_data_o); end
  endtask

  task automatic test_store_wait();
    set_op(5'd0, 1'b0, 1'b1, SIZE_B, 32'h103, 32'hAABBCCDD);
    dmem_gnt_i = 1'b0;
    tick();
    set_nop();
    checks++; if ({dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o, rd_we_o} !== {32'h100, 4'b1000, 32'hDDDDDDDD, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL sb_bus: got addr=%h be=%b wdata=%h we=%b rd_we=%b, expected 00000100 1000 dddddddd 1 0", dmem_addr_o, dmem_be_o, dmem_wdata_o, dmem_we_o, rd_we_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({dmem_req_o, stall_o, dmem_be_o} !== {1'b1, 1'b1, 4'b1000}) begin
        errors++; $display("[TB] FAIL sb_wait%0d: got req=%b stall=%b be=%b, expected 1 1 1000", i, dmem_req_o, stall_o, dmem_be_o); end
      if (i < 2) tick();
    end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    checks++; if ({dmem_req_o, stall_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL sb_done: got req=%b stall=%b, expected 0 0", dmem_req_o, stall_o); end
  endtask

  task automatic test_load(input string name, input data_size_e size, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] expected);
    set_op(rd, 1'b1, 1'b0, size, addr, 32'h0);
    tick();
    set_nop();
    checks++; if ({dmem_req_o, dmem_we_o, stall_o, dmem_addr_o} !== {1'b1, 1'b0, 1'b1, addr[31:2], 2'b00}) begin
      errors++; $display("[TB] FAIL %s_req: got req=%b we=%b stall=%b addr=%h, expected 1 0 1 %h", name, dmem_req_o, dmem_we_o, stall_o, dmem_addr_o, {addr[31:2], 2'b00}); end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = rdata;
    checks++; if ({stall_o, dmem_req_o, rd_we_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL %s_resp: got stall=%b req=%b rd_we=%b, expected 1 0 0", name, stall_o, dmem_req_o, rd_we_o); end
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    checks++; if ({rd_we_o, sel_rd_o, rd_data_o, stall_o} !== {1'b1, rd, expected, 1'b0}) begin
      errors++; $display("[TB] FAIL %s_wb: got we=%b rd=%0d data=%h stall=%b, expected 1 %0d %h 0", name, rd_we_o, sel_rd_o, rd_data_o, stall_o, rd, expected); end
  endtask

  task automatic test_misalign();
    set_op(5'd3, 1'b1, 1'b0, SIZE_W, 32'h006, 32'h0);
    tick();
    set_nop();
    checks++; if ({misalign_o, dmem_req_o, rd_we_o, stall_o} !== 4'b1000) begin
      errors++; $display("[TB] FAIL lw_misalign: got mis=%b req=%b rd_we=%b stall=%b, expected 1 0 0 0", misalign_o, dmem_req_o, rd_we_o, stall_o); end
    tick();
    checks++; if ({misalign_o, dmem_req_o} !== 2'b00) begin
      errors++; $display("[TB] FAIL misalign_pulse: got mis=%b req=%b, expected 0 0", misalign_o, dmem_req_o); end
    set_op(5'd2, 1'b0, 1'b1, SIZE_H, 32'h201, 32'h1);
    tick();
    set_nop();
    checks++; if ({misalign_o, dmem_req_o, stall_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL sh_misalign: got mis=%b req=%b stall=%b, expected 1 0 0", misalign_o, dmem_req_o, stall_o); end
    tick();
  endtask

  task automatic test_reset_in_resp();
    set_op(5'd9, 1'b1, 1'b0, SIZE_W, 32'h10, 32'h0);
    tick();
    set_nop();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    repeat (3) tick();
    checks++; if ({stall_o, dmem_req_o, rd_we_o} !== 3'b100) begin
      errors++; $display("[TB] FAIL resp_wait: got stall=%b req=%b rd_we=%b, expected 1 0 0", stall_o, dmem_req_o, rd_we_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, sel_rd_o, rd_we_o, rd_data_o, misalign_o} !== '0) begin
      errors++; $display("[TB] FAIL async_reset: got stall=%b addr=%h be=%b rd_we=%b, expected all zero", stall_o, dmem_addr_o, dmem_be_o, rd_we_o); end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hFFFFFFFF;
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    checks++; if ({stall_o, rd_we_o, sel_rd_o, rd_data_o} !== '0) begin
      errors++; $display("[TB] FAIL late_rvalid: got stall=%b rd_we=%b rd=%0d data=%h, expected all zero", stall_o, rd_we_o, sel_rd_o, rd_data_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mem_word;
    mem_word = 32'hCAFEF00D;
    set_op(5'd0, 1'b0, 1'b1, SIZE_W, 32'h40, mem_word);
    tick();
    set_op(5'd4, 1'b1, 1'b0, SIZE_W, 32'h40, 32'h0);
    checks++; if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o} !== {1'b1, 1'b1, 32'h40, 4'hF, mem_word}) begin
      errors++; $display("[TB] FAIL b2b_sw: got req=%b we=%b addr=%h be=%b wdata=%h, expected 1 1 00000040 1111 %h", dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, mem_word); end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    tick();
    set_op(5'd6, 1'b0, 1'b0, SIZE_W, 32'h55, 32'h0);
    checks++; if ({dmem_req_o, dmem_we_o, dmem_addr_o, rd_we_o} !== {1'b1, 1'b0, 32'h40, 1'b0}) begin
      errors++; $display("[TB] FAIL b2b_lw_req: got req=%b we=%b addr=%h rd_we=%b, expected 1 0 00000040 0", dmem_req_o, dmem_we_o, dmem_addr_o, rd_we_o); end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = mem_word;
    checks++; if (rd_we_o !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_early_wb: got rd_we=%b, expected 0", rd_we_o); end
    tick();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    checks++; if ({rd_we_o, sel_rd_o, rd_data_o, stall_o} !== {1'b1, 5'd4, mem_word, 1'b0}) begin
      errors++; $display("[TB] FAIL b2b_lw_wb: got we=%b rd=%0d data=%h stall=%b, expected 1 4 %h 0", rd_we_o, sel_rd_o, rd_data_o, stall_o, mem_word); end
    tick();
    set_nop();
    checks++; if ({rd_we_o, sel_rd_o, rd_data_o} !== {1'b1, 5'd6, 32'h55}) begin
      errors++; $display("[TB] FAIL b2b_add_wb: got we=%b rd=%0d data=%h, expected 1 6 00000055", rd_we_o, sel_rd_o, rd_data_o); end
  endtask

  initial begin
    rst_n = 1'b0;
    set_nop();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 32'h0;
    test_reset();
    test_alu();
    test_store_wait();
    test_load("lb",  SIZE_B,  32'h102, 32'h00800000, 5'd7, 32'hFFFFFF80);
    test_load("lbu", SIZE_BU, 32'h102, 32'h00800000, 5'd7, 32'h00000080);
    test_load("lh",  SIZE_H,  32'h102, 32'h80010000, 5'd8, 32'hFFFF8001);
    test_load("lhu", SIZE_HU, 32'h102, 32'h80010000, 5'd8, 32'h00008001);
    test_load("lw",  SIZE_W,  32'h200, 32'h12345678, 5'd1, 32'h12345678);
    test_misalign();
    test_reset_in_resp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
